// File: rtl/rom_fetch_unit.sv
// Instruction-fetch front end: drives the synchronous program ROM, absorbs its
// one-cycle read latency and buffers fetched bytes in a small prefetch FIFO.
module rom_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
  input  logic [DATA_WIDTH-1:0] ROM_DATA,
  input  logic                  HALT,
  input  logic                  REDIRECT,
  input  logic [ADDR_WIDTH-1:0] REDIRECT_ADDR,
  output logic [DATA_WIDTH-1:0] INSTR_DATA,
  output logic [ADDR_WIDTH-1:0] INSTR_ADDR,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  inflight_r;
  logic [ADDR_WIDTH-1:0] inflight_addr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [DATA_WIDTH-1:0] mem_data_r [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr_r [DEPTH];

  logic          valid_s;
  logic          pop_s;
  logic          push_s;
  logic          issue_s;
  logic [CW:0]   occ_s;

  // Handshake and issue decisions for the current cycle
  always_comb begin
    valid_s = 1'b0;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    issue_s = 1'b0;
    occ_s   = {(CW+1){1'b0}};
    if (count_r != {CW{1'b0}}) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    pop_s  = valid_s & INSTR_READY & ~REDIRECT;
    push_s = inflight_r & ~REDIRECT;
    // Slots already promised (buffered + in flight) minus the one leaving now
    occ_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
    if (occ_s < DEPTH_V) begin
      issue_s = ~HALT & ~REDIRECT;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch PC, in-flight tracking, FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_r            <= RESET_PC;
      inflight_r      <= 1'b0;
      inflight_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_ptr_r        <= {PW{1'b0}};
      rd_ptr_r        <= {PW{1'b0}};
      count_r         <= {CW{1'b0}};
    end else if (REDIRECT) begin
      pc_r            <= REDIRECT_ADDR;
      inflight_r      <= 1'b0;
      inflight_addr_r <= inflight_addr_r;
      wr_ptr_r        <= {PW{1'b0}};
      rd_ptr_r        <= {PW{1'b0}};
      count_r         <= {CW{1'b0}};
    end else begin
      if (issue_s) begin
        pc_r            <= pc_r + ADDR_WIDTH'(1);
        inflight_r      <= 1'b1;
        inflight_addr_r <= pc_r;
      end else begin
        inflight_r      <= 1'b0;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: captures the ROM byte together with the address it came from
  always_ff @(posedge CLK) begin
    if (!RESET && push_s) begin
      mem_data_r[wr_ptr_r] <= ROM_DATA;
      mem_addr_r[wr_ptr_r] <= inflight_addr_r;
    end
  end

  // Decoder-facing head of the FIFO, forced to zero while empty
  always_comb begin
    INSTR_VALID = valid_s;
    if (valid_s) begin
      INSTR_DATA = mem_data_r[rd_ptr_r];
      INSTR_ADDR = mem_addr_r[rd_ptr_r];
    end else begin
      INSTR_DATA = {DATA_WIDTH{1'b0}};
      INSTR_ADDR = {ADDR_WIDTH{1'b0}};
    end
  end

  assign ROM_ADDRESS = pc_r;

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Directed bench for rom_fetch_unit against a ROM holding ROM[i] = i ^ 8'hA5.
module tb_rom_fetch_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] ROM_ADDRESS;
  logic [7:0] ROM_DATA;
  logic       HALT;
  logic       REDIRECT;
  logic [7:0] REDIRECT_ADDR;
  logic [7:0] INSTR_DATA;
  logic [7:0] INSTR_ADDR;
  logic       INSTR_VALID;
  logic       INSTR_READY;

  int tests = 0;
  int fails = 0;

  rom_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .ROM_ADDRESS(ROM_ADDRESS), .ROM_DATA(ROM_DATA),
    .HALT(HALT), .REDIRECT(REDIRECT), .REDIRECT_ADDR(REDIRECT_ADDR),
    .INSTR_DATA(INSTR_DATA), .INSTR_ADDR(INSTR_ADDR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY)
  );

  always #5 CLK = ~CLK;

  // Registered-output program ROM
  always_ff @(posedge CLK) ROM_DATA <= ROM_ADDRESS ^ 8'hA5;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk_head(input string tag, input logic [7:0] a);
    chk({tag, "_valid"}, {7'h0, INSTR_VALID}, 8'h01);
    chk({tag, "_addr"}, INSTR_ADDR, a);
    chk({tag, "_data"}, INSTR_DATA, a ^ 8'hA5);
  endtask

  initial begin
    RESET = 1'b1; HALT = 1'b0; REDIRECT = 1'b0; REDIRECT_ADDR = 8'h00; INSTR_READY = 1'b1;
    step(); step();
    chk("rst_romaddr", ROM_ADDRESS, 8'h00);
    chk("rst_valid", {7'h0, INSTR_VALID}, 8'h00);
    chk("rst_data", INSTR_DATA, 8'h00);
    chk("rst_addr", INSTR_ADDR, 8'h00);

    // Streaming from reset: first byte in cycle 2, then one per cycle
    RESET = 1'b0;                                   // cycle 0
    step(); chk("s1_c1_valid", {7'h0, INSTR_VALID}, 8'h00);
    step();
    chk("s1_first_data", INSTR_DATA, 8'hA5);
    chk("s1_romaddr_c2", ROM_ADDRESS, 8'h02);
    for (int i = 0; i < 6; i++) begin
      chk_head("s1_stream", 8'(i));
      step();
    end

    // Backpressure: exactly four bytes buffered, PC parked at 0x04
    RESET = 1'b1; INSTR_READY = 1'b0;
    step();
    RESET = 1'b0;
    repeat (6) step();
    chk("s2_romaddr_hold", ROM_ADDRESS, 8'h04);
    chk_head("s2_head", 8'h00);
    step(); step();
    chk("s2_romaddr_hold2", ROM_ADDRESS, 8'h04);
    chk_head("s2_stable", 8'h00);
    INSTR_READY = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      chk_head("s2_drain", 8'(i));
    end

    // Redirect with three buffered bytes and one read in flight
    RESET = 1'b1; INSTR_READY = 1'b0;
    step();
    RESET = 1'b0;
    repeat (4) step();
    chk_head("s3_pre", 8'h00);
    REDIRECT = 1'b1; REDIRECT_ADDR = 8'h80; INSTR_READY = 1'b1;
    step(); REDIRECT = 1'b0;
    chk("s3_r1_valid", {7'h0, INSTR_VALID}, 8'h00);
    chk("s3_r1_romaddr", ROM_ADDRESS, 8'h80);
    step();
    chk("s3_r2_valid", {7'h0, INSTR_VALID}, 8'h00);
    step();
    chk("s3_target_data", INSTR_DATA, 8'h25);
    chk_head("s3_r3", 8'h80);
    step(); chk_head("s3_r4", 8'h81);
    step(); chk_head("s3_r5", 8'h82);

    // Redirect across the address wrap
    REDIRECT = 1'b1; REDIRECT_ADDR = 8'hFE;
    step(); REDIRECT = 1'b0;
    step(); step();
    chk("s4_fe_data", INSTR_DATA, 8'h5B);
    chk_head("s4_fe", 8'hFE);
    step(); chk_head("s4_ff", 8'hFF);
    step(); chk("s4_00_data", INSTR_DATA, 8'hA5); chk_head("s4_00", 8'h00);
    step(); chk_head("s4_01", 8'h01);

    // HALT for five cycles mid-stream: one more byte, then drain, then resume at 0x03
    HALT = 1'b1;
    step(); chk_head("s5_last", 8'h02);
    step(); chk("s5_h2_valid", {7'h0, INSTR_VALID}, 8'h00);
    step(); chk("s5_h3_valid", {7'h0, INSTR_VALID}, 8'h00);
    chk("s5_h3_romaddr", ROM_ADDRESS, 8'h03);
    step(); chk("s5_h4_valid", {7'h0, INSTR_VALID}, 8'h00);
    step(); chk("s5_h5_valid", {7'h0, INSTR_VALID}, 8'h00);
    HALT = 1'b0;
    step(); chk("s5_h6_valid", {7'h0, INSTR_VALID}, 8'h00);
    step(); chk("s5_resume_data", INSTR_DATA, 8'hA6); chk_head("s5_resume", 8'h03);
    step(); chk_head("s5_next", 8'h04);

    // Reset coinciding with a redirect while the FIFO is full
    INSTR_READY = 1'b0;
    repeat (6) step();
    chk("s6_full_valid", {7'h0, INSTR_VALID}, 8'h01);
    RESET = 1'b1; REDIRECT = 1'b1; REDIRECT_ADDR = 8'h40; INSTR_READY = 1'b1;
    step();
    chk("s6_valid", {7'h0, INSTR_VALID}, 8'h00);
    chk("s6_romaddr", ROM_ADDRESS, 8'h00);
    chk("s6_data", INSTR_DATA, 8'h00);
    chk("s6_addr", INSTR_ADDR, 8'h00);
    RESET = 1'b0; REDIRECT = 1'b0;
    step(); chk("s6_c1_valid", {7'h0, INSTR_VALID}, 8'h00);
    step(); chk_head("s6_restart0", 8'h00);
    step(); chk_head("s6_restart1", 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
